// File: rtl/reg_write_stage.sv
// reg_write_stage
//   Final pipeline stage. Retires one op per cycle from the execute stage:
//   commits its result to the int or fp register file and counts retired
//   instructions. Traps and xRETs are sequenced through a small FSM. The FSM
//   pulses the CSR unit, then redirects fetch, and stalls upstream until the
//   sequence ends.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_*                      registered op from the execute stage
//   csr_trap_vector, csr_epc  redirect targets supplied by the CSR unit
//   int_we/waddr/wdata        int register file write port (zero latency)
//   fp_we/waddr/wdata         fp register file write port (zero latency)
//   csr_trap_begin            one-cycle pulse; the CSR unit latches csr_trap_cause/value/pc
//   csr_trap_return           one-cycle pulse; the CSR unit restores privilege
//   redirect_valid/pc         one-cycle fetch redirect
//   stall_req                 hold upstream stages
//   retired_count             retired-instruction counter (wraps)
//   debug_retire_*            retire trace
module reg_write_stage #(
    parameter int XLEN        = 32,
    parameter int FLEN        = 64,
    parameter int CAUSE_WIDTH = 4,
    parameter int COUNT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_insn,
    input  logic                   in_reg_write_enable,
    input  logic                   in_dst_reg_type,
    input  logic [4:0]             in_dst_reg_addr,
    input  logic [XLEN-1:0]        in_dst_int_value,
    input  logic [FLEN-1:0]        in_dst_fp_value,
    input  logic                   in_trap_valid,
    input  logic [CAUSE_WIDTH-1:0] in_trap_cause,
    input  logic [XLEN-1:0]        in_trap_value,
    input  logic                   in_trap_return,
    input  logic [XLEN-1:0]        csr_trap_vector,
    input  logic [XLEN-1:0]        csr_epc,
    output logic                   int_we,
    output logic [4:0]             int_waddr,
    output logic [XLEN-1:0]        int_wdata,
    output logic                   fp_we,
    output logic [4:0]             fp_waddr,
    output logic [FLEN-1:0]        fp_wdata,
    output logic                   csr_trap_begin,
    output logic [CAUSE_WIDTH-1:0] csr_trap_cause,
    output logic [XLEN-1:0]        csr_trap_value,
    output logic [XLEN-1:0]        csr_trap_pc,
    output logic                   csr_trap_return,
    output logic                   redirect_valid,
    output logic [XLEN-1:0]        redirect_pc,
    output logic                   stall_req,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic                   debug_retire_valid,
    output logic [XLEN-1:0]        debug_retire_pc,
    output logic [31:0]            debug_retire_insn
);

    localparam logic [2:0] IDLE          = 3'd0;
    localparam logic [2:0] TRAP_CSR      = 3'd1;
    localparam logic [2:0] TRAP_REDIRECT = 3'd2;
    localparam logic [2:0] RET_CSR       = 3'd3;
    localparam logic [2:0] RET_REDIRECT  = 3'd4;

    logic [2:0] state;
    logic [2:0] state_next;

    logic idle;
    logic commit;
    logic trap_accept;
    logic ret_accept;

    // Op classification. Only IDLE looks at in_valid; while a sequence runs
    // the upstream contents are about to be flushed by the redirect.
    always_comb begin
        idle        = (state == IDLE);
        trap_accept = idle && in_valid && in_trap_valid;
        ret_accept  = idle && in_valid && in_trap_return && !in_trap_valid;
        commit      = idle && in_valid && !in_trap_valid && !in_trap_return;
    end

    // Register file write ports. x0 is hardwired zero, but f0 is a real register.
    always_comb begin
        int_we    = commit && in_reg_write_enable && !in_dst_reg_type &&
                    (in_dst_reg_addr != 5'd0);
        fp_we     = commit && in_reg_write_enable && in_dst_reg_type;
        int_waddr = int_we ? in_dst_reg_addr  : 5'd0;
        int_wdata = int_we ? in_dst_int_value : '0;
        fp_waddr  = fp_we  ? in_dst_reg_addr  : 5'd0;
        fp_wdata  = fp_we  ? in_dst_fp_value  : '0;
    end

    // Retire trace. An xRET retires, but a trapping op does not.
    always_comb begin
        debug_retire_valid = commit || ret_accept;
        debug_retire_pc    = debug_retire_valid ? in_pc   : '0;
        debug_retire_insn  = debug_retire_valid ? in_insn : 32'd0;
    end

    // Sequence outputs. Redirect targets are sampled in the redirect cycle,
    // so the CSR unit has had the pulse cycle to update them.
    always_comb begin
        csr_trap_begin  = (state == TRAP_CSR);
        csr_trap_return = (state == RET_CSR);
        redirect_valid  = (state == TRAP_REDIRECT) || (state == RET_REDIRECT);
        redirect_pc     = '0;
        if (state == TRAP_REDIRECT) begin
            redirect_pc = csr_trap_vector;
        end else if (state == RET_REDIRECT) begin
            redirect_pc = csr_epc;
        end
        stall_req = !idle || trap_accept || ret_accept;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trap_accept) begin
                    state_next = TRAP_CSR;
                end else if (ret_accept) begin
                    state_next = RET_CSR;
                end
            end
            TRAP_CSR:      state_next = TRAP_REDIRECT;
            TRAP_REDIRECT: state_next = IDLE;
            RET_CSR:       state_next = RET_REDIRECT;
            RET_REDIRECT:  state_next = IDLE;
            default:       state_next = IDLE;
        endcase
    end

    // State, retire counter and captured trap data
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            retired_count  <= '0;
            csr_trap_cause <= '0;
            csr_trap_value <= '0;
            csr_trap_pc    <= '0;
        end else begin
            state <= state_next;
            if (commit || ret_accept) begin
                retired_count <= retired_count + COUNT_WIDTH'(1);
            end
            if (trap_accept) begin
                csr_trap_cause <= in_trap_cause;
                csr_trap_value <= in_trap_value;
                csr_trap_pc    <= in_pc;
            end
        end
    end

endmodule

// File: doc/reg_write_stage.md
Name: reg_write_stage

Overview:
- Final pipeline stage; consumes the registered outputs of the execute stage (one op per cycle).
- Retires each op: commits its result to the int or fp register file and counts retired instructions.
- Sequences traps and trap returns through a multi-cycle FSM that updates trap CSRs and redirects fetch.
- Holds the upstream pipeline with a stall request while a trap or trap return is in progress.

Parameters:
XLEN, 32, integer datapath / pc width
FLEN, 64, fp register width
CAUSE_WIDTH, 4, exception cause code width
COUNT_WIDTH, 64, retired-instruction counter width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  op present this cycle
in_pc  input  XLEN  pc of op
in_insn  input  32  raw instruction (debug only)
in_reg_write_enable  input  1  op writes a destination register
in_dst_reg_type  input  1  0=int, 1=fp
in_dst_reg_addr  input  5  destination register
in_dst_int_value  input  XLEN  int result
in_dst_fp_value  input  FLEN  fp result
in_trap_valid  input  1  op raised an exception
in_trap_cause  input  CAUSE_WIDTH  exception code
in_trap_value  input  XLEN  tval
in_trap_return  input  1  op is xRET
csr_trap_vector  input  XLEN  handler address from CSR unit
csr_epc  input  XLEN  return address from CSR unit
int_we / int_waddr / int_wdata  output  1/5/XLEN  int regfile write port
fp_we / fp_waddr / fp_wdata  output  1/5/FLEN  fp regfile write port
csr_trap_begin  output  1  one-cycle pulse: CSR unit latches cause/value/pc
csr_trap_cause / csr_trap_value / csr_trap_pc  output  CAUSE_WIDTH/XLEN/XLEN  captured trap data
csr_trap_return  output  1  one-cycle pulse: CSR unit restores privilege
redirect_valid / redirect_pc  output  1/XLEN  fetch redirect, one-cycle pulse
stall_req  output  1  hold upstream stages
retired_count  output  COUNT_WIDTH  instructions retired
debug_retire_valid / debug_retire_pc / debug_retire_insn  output  1/XLEN/32  retire trace

Behaviour:
- Reset: state=IDLE; retired_count=0; captured trap regs=0; all pulse/write-enable outputs 0; data outputs 0.
- Commit occurs in IDLE when in_valid && !in_trap_valid && !in_trap_return.
- Register writes are combinational in the commit cycle (zero latency):
  - int_we = commit && in_reg_write_enable && type==0 && addr!=0.
  - fp_we = commit && in_reg_write_enable && type==1 (f0 is writable).
  - Data and address pass through; write ports are driven 0 when the enable is low.
- Trapping ops write no register; xRET writes no register.
- retired_count increments by 1 on a commit and on an xRET acceptance; it does not increment on a trap. Wraps modulo 2^COUNT_WIDTH.
- debug_retire_valid mirrors the increment condition, combinationally.
- FSM states: IDLE, TRAP_CSR, TRAP_REDIRECT, RET_CSR, RET_REDIRECT.
  - IDLE, in_valid && in_trap_valid: capture cause/value/pc -> TRAP_CSR. Trap has priority if in_trap_return is also set.
  - IDLE, in_valid && in_trap_return && !in_trap_valid -> RET_CSR.
  - TRAP_CSR: csr_trap_begin=1 with captured values -> TRAP_REDIRECT.
  - TRAP_REDIRECT: redirect_valid=1, redirect_pc=csr_trap_vector (sampled this cycle) -> IDLE.
  - RET_CSR: csr_trap_return=1 -> RET_REDIRECT.
  - RET_REDIRECT: redirect_valid=1, redirect_pc=csr_epc -> IDLE.
- stall_req = (state!=IDLE) || (state==IDLE && in_valid && (in_trap_valid || in_trap_return)).
  - Trap and return sequences are therefore 3 cycles: accept, CSR, redirect.
- In any non-IDLE state, in_valid is ignored (upstream is flushed by the redirect); no writes and no count.
- csr_trap_* data outputs hold the captured values in all states (0 after reset). Captured regs update only on trap acceptance.
- rst asserted mid-sequence: return to IDLE next edge; no csr pulse or redirect is issued afterwards.
- Back-to-back: a trap op arriving the cycle after RET_REDIRECT/TRAP_REDIRECT (state IDLE) is accepted normally.

Test Plan:
- Reset, then in_valid with int write to x5=0xDEADBEEF -> int_we=1, waddr=5, wdata=0xDEADBEEF the same cycle; retired_count=1 next cycle; stall_req=0.
- Int write to x0 with value 0x1234 -> int_we=0; retired_count still increments. Fp write to f0=0x3F800000 -> fp_we=1.
- Trap cause=2, value=0x00000013, pc=0x80000100, csr_trap_vector=0x80000004 -> stall_req=1 for 3 cycles; csr_trap_begin in cycle+1 with those values; redirect_valid with pc 0x80000004 in cycle+2; no reg write; count unchanged.
- xRET with csr_epc=0x80000200 -> csr_trap_return pulse at +1, redirect to 0x80000200 at +2; count +1; in_valid ops during +1/+2 are ignored.
- Both trap and return set together -> trap path taken. Assert rst in TRAP_CSR -> no redirect issued, state IDLE, retired_count=0.
- Preload retired_count to all-ones via 2^64-1 commits (or a force) and commit once -> wraps to 0.
